// File: rtl/wdec_pkg.sv
// Shared types and token field constants for the weight-coded stream decoder.
package wdec_pkg;

    typedef enum logic [2:0] {
        BLANK,
        TOKEN,
        LIT,
        REP,
        INC,
        CSUM
    } state_t;

    typedef enum logic [1:0] {
        KIND_LIT,
        KIND_REP,
        KIND_INC
    } tok_kind_t;

    localparam int         LIT_FLAG     = 7;
    localparam int         RUN_KIND     = 6;
    localparam logic [6:0] LIT_CNT_MASK = 7'h7F;
    localparam logic [5:0] RUN_CNT_MASK = 6'h3F;

endpackage

// File: rtl/wdec_token.sv
// Combinational token classifier: returns the token kind and its run length minus one.
module wdec_token
    import wdec_pkg::*;
(
    input  logic [7:0] token,
    output tok_kind_t  kind,
    output logic [6:0] run
);

    always_comb begin
        kind = KIND_LIT;
        run  = token[6:0] & LIT_CNT_MASK;
        if (token[LIT_FLAG]) begin
            kind = token[RUN_KIND] ? KIND_INC : KIND_REP;
            run  = {1'b0, token[5:0] & RUN_CNT_MASK};
        end
    end

endmodule

// File: rtl/wdecoder.sv
// Weight-coded stream decoder: expands literal/repeat/increment tokens into framed pixel lines.
// Optional end-of-line checksum byte is enabled with the WDEC_CHECKSUM_EN macro.
module wdecoder
    import wdec_pkg::*;
#(
    parameter int LINE_PIX = 1010,
    parameter int HBLANK   = 4
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       din_valid,
    input  logic [7:0] din,
    output logic       din_ack,
    output logic       href,
    output logic       pix_valid,
    output logic [7:0] dout,
    output logic       err
);

    localparam int CNT_W = $clog2(LINE_PIX + 1);
    localparam int BLK_W = $clog2(HBLANK + 1);

`ifdef WDEC_CHECKSUM_EN
    localparam state_t END_STATE = CSUM;
    localparam logic   END_ACK   = 1'b1;
`else
    localparam state_t END_STATE = BLANK;
    localparam logic   END_ACK   = 1'b0;
`endif

    state_t           state;
    logic [CNT_W-1:0] pix_cnt;
    logic [BLK_W-1:0] blank_cnt;
    logic [7:0]       prev;
    logic [6:0]       run_cnt;
    tok_kind_t        tok_kind;
    logic [6:0]       tok_run;
    logic             emit;
    logic [7:0]       emit_val;
`ifdef WDEC_CHECKSUM_EN
    logic [7:0]       sum;
`endif

    wire xfer      = din_valid && din_ack;
    wire last_pix  = (pix_cnt == CNT_W'(LINE_PIX - 1));
    wire line_done = (pix_cnt == CNT_W'(LINE_PIX));

    wdec_token u_token (
        .token (din),
        .kind  (tok_kind),
        .run   (tok_run)
    );

    // Once the line is full, further literal bytes are drained without emitting.
    always_comb begin
        emit     = 1'b0;
        emit_val = din;
        case (state)
            LIT:     emit = xfer && !line_done;
            REP:     begin emit = 1'b1; emit_val = prev; end
            INC:     begin emit = 1'b1; emit_val = prev + 8'd1; end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BLANK;
            din_ack   <= 1'b0;
            href      <= 1'b0;
            pix_valid <= 1'b0;
            dout      <= 8'd0;
            err       <= 1'b0;
            pix_cnt   <= '0;
            blank_cnt <= '0;
            prev      <= 8'd0;
            run_cnt   <= 7'd0;
`ifdef WDEC_CHECKSUM_EN
            sum       <= 8'd0;
`endif
        end else begin
            pix_valid <= emit;
            if (emit) begin
                dout    <= emit_val;
                prev    <= emit_val;
                href    <= 1'b1;
                pix_cnt <= pix_cnt + CNT_W'(1);
`ifdef WDEC_CHECKSUM_EN
                sum     <= sum + emit_val;
`endif
            end

            case (state)
                BLANK: begin
                    href    <= 1'b0;
                    pix_cnt <= '0;
                    prev    <= 8'd0;
`ifdef WDEC_CHECKSUM_EN
                    sum     <= 8'd0;
`endif
                    if (blank_cnt == BLK_W'(HBLANK - 1)) begin
                        blank_cnt <= '0;
                        state     <= TOKEN;
                        din_ack   <= 1'b1;
                    end else begin
                        blank_cnt <= blank_cnt + BLK_W'(1);
                    end
                end

                TOKEN: begin
                    if (xfer) begin
                        run_cnt <= tok_run;
                        case (tok_kind)
                            KIND_LIT: state <= LIT;
                            KIND_REP: begin state <= REP; din_ack <= 1'b0; end
                            default:  begin state <= INC; din_ack <= 1'b0; end
                        endcase
                    end
                end

                LIT: begin
                    if (line_done) begin
                        href <= 1'b0;
                    end
                    if (xfer) begin
                        if ((line_done || last_pix) && run_cnt == 7'd0) begin
                            state     <= END_STATE;
                            din_ack   <= END_ACK;
                            blank_cnt <= '0;
                        end else if (line_done || last_pix) begin
                            if (last_pix) begin
                                err <= 1'b1;
                            end
                            run_cnt <= run_cnt - 7'd1;
                        end else if (run_cnt == 7'd0) begin
                            state <= TOKEN;
                        end else begin
                            run_cnt <= run_cnt - 7'd1;
                        end
                    end
                end

                REP, INC: begin
                    if (last_pix) begin
                        if (run_cnt != 7'd0) begin
                            err <= 1'b1;
                        end
                        state     <= END_STATE;
                        din_ack   <= END_ACK;
                        blank_cnt <= '0;
                    end else if (run_cnt == 7'd0) begin
                        state   <= TOKEN;
                        din_ack <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt - 7'd1;
                    end
                end

`ifdef WDEC_CHECKSUM_EN
                CSUM: begin
                    href <= 1'b0;
                    if (xfer) begin
                        if (din != sum) begin
                            err <= 1'b1;
                        end
                        state     <= BLANK;
                        din_ack   <= 1'b0;
                        blank_cnt <= '0;
                    end
                end
`endif

                default: begin
                    state   <= BLANK;
                    din_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wdecoder.sv
// Scoreboard bench for wdecoder with short lines; checksum bytes are appended when WDEC_CHECKSUM_EN is defined.
module tb_wdecoder;

    localparam int LINE_PIX = 4;
    localparam int HBLANK   = 4;

`ifdef WDEC_CHECKSUM_EN
    localparam logic [7:0] END_ACK = 8'd1;
`else
    localparam logic [7:0] END_ACK = 8'd0;
`endif

    logic       pclk      = 1'b0;
    logic       rst_n     = 1'b0;
    logic       din_valid = 1'b0;
    logic [7:0] din       = 8'd0;
    logic       din_ack;
    logic       href;
    logic       pix_valid;
    logic [7:0] dout;
    logic       err;

    int         compared = 0;
    int         failed   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] line_sum = 8'd0;

    wdecoder #(
        .LINE_PIX (LINE_PIX),
        .HBLANK   (HBLANK)
    ) dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .din_valid (din_valid),
        .din       (din),
        .din_ack   (din_ack),
        .href      (href),
        .pix_valid (pix_valid),
        .dout      (dout),
        .err       (err)
    );

    always #5 pclk = ~pclk;

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, actual, expected, $time);
        end
    endtask

    // Offer one byte and hold it until the decoder accepts it.
    task automatic apply_stimulus(input logic [7:0] b);
        int waited;
        waited    = 0;
        din       = b;
        din_valid = 1'b1;
        while (din_ack !== 1'b1 && waited < 100) begin
            @(negedge pclk);
            waited++;
        end
        if (waited >= 100) begin
            compared++;
            failed++;
            $display("[TB] FAIL ack_timeout: byte %02h never accepted at %0t", b, $time);
            din_valid = 1'b0;
            return;
        end
        @(posedge pclk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic push_pix(input logic [7:0] b);
        exp_q.push_back(b);
        line_sum = line_sum + b;
    endtask

    // Wait for the scoreboard to drain, then href must already be low.
    task automatic finish_line();
        int n;
        n = 0;
        do begin
            @(posedge pclk);
            #1;
            n++;
        end while (exp_q.size() != 0 && n < 100);
        if (exp_q.size() != 0) begin
            compared++;
            failed++;
            $display("[TB] FAIL line_timeout: %0d pixels still expected at %0t", exp_q.size(), $time);
        end
        check_output("href_after_line", 8'(href), 8'd0);
        check_output("ack_after_line", 8'(din_ack), END_ACK);
    endtask

    task automatic send_csum();
`ifdef WDEC_CHECKSUM_EN
        apply_stimulus(line_sum);
`endif
        line_sum = 8'd0;
    endtask

    task automatic check_reset_outputs();
        check_output("rst_din_ack", 8'(din_ack), 8'd0);
        check_output("rst_href", 8'(href), 8'd0);
        check_output("rst_pix_valid", 8'(pix_valid), 8'd0);
        check_output("rst_dout", dout, 8'd0);
        check_output("rst_err", 8'(err), 8'd0);
    endtask

    always @(negedge pclk) begin
        if (rst_n && pix_valid) begin
            if (exp_q.size() == 0) begin
                compared++;
                failed++;
                $display("[TB] FAIL unexpected_pixel: got %02h with empty scoreboard at %0t", dout, $time);
            end else begin
                check_output("pixel", dout, exp_q.pop_front());
                check_output("href_with_pixel", 8'(href), 8'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #3;
        check_reset_outputs();
        @(negedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;

        // Reset in the middle of a repeat run.
        apply_stimulus(8'h00);
        push_pix(8'h05);
        apply_stimulus(8'h05);
        apply_stimulus(8'h82);
        check_output("ack_in_rep", 8'(din_ack), 8'd0);
        @(posedge pclk);
        #2;
        check_output("rep_first_valid", 8'(pix_valid), 8'd1);
        check_output("rep_first_pixel", dout, 8'h05);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        line_sum = 8'd0;
        @(negedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;
        for (int i = 0; i < HBLANK - 1; i++) begin
            @(negedge pclk);
            check_output("blank_href", 8'(href), 8'd0);
            check_output("blank_ack", 8'(din_ack), 8'd0);
        end
        @(negedge pclk);
        check_output("token_ack_after_blank", 8'(din_ack), 8'd1);

        $display("[TB] literal line");
        apply_stimulus(8'h03);
        push_pix(8'h10); apply_stimulus(8'h10);
        push_pix(8'h20); apply_stimulus(8'h20);
        push_pix(8'h30); apply_stimulus(8'h30);
        push_pix(8'h40); apply_stimulus(8'h40);
        finish_line();
        send_csum();

        $display("[TB] increment run with wrap");
        apply_stimulus(8'h00);
        push_pix(8'hFD);
        apply_stimulus(8'hFD);
        push_pix(8'hFE); push_pix(8'hFF); push_pix(8'h00);
        apply_stimulus(8'hC2);
        finish_line();
        check_output("err_after_inc", 8'(err), 8'd0);
        send_csum();

        $display("[TB] repeat with stall");
        apply_stimulus(8'h00);
        push_pix(8'h07);
        apply_stimulus(8'h07);
        repeat (3) begin
            @(posedge pclk);
            #1;
            check_output("stall_href", 8'(href), 8'd1);
            check_output("stall_pix_valid", 8'(pix_valid), 8'd0);
        end
        push_pix(8'h07); push_pix(8'h07); push_pix(8'h07);
        apply_stimulus(8'h82);
        check_output("ack_in_rep2", 8'(din_ack), 8'd0);
        finish_line();
        send_csum();

        $display("[TB] literal overrun");
        apply_stimulus(8'h05);
        push_pix(8'hAA); apply_stimulus(8'hAA);
        push_pix(8'hBB); apply_stimulus(8'hBB);
        push_pix(8'hCC); apply_stimulus(8'hCC);
        push_pix(8'hDD); apply_stimulus(8'hDD);
        apply_stimulus(8'hEE);
        apply_stimulus(8'hFF);
        finish_line();
        check_output("err_after_overrun", 8'(err), 8'd1);
        send_csum();

        $display("[TB] good line keeps sticky err");
        apply_stimulus(8'h03);
        push_pix(8'h01); apply_stimulus(8'h01);
        push_pix(8'h02); apply_stimulus(8'h02);
        push_pix(8'h03); apply_stimulus(8'h03);
        push_pix(8'h04); apply_stimulus(8'h04);
        finish_line();
        check_output("err_sticky", 8'(err), 8'd1);
        send_csum();

`ifdef WDEC_CHECKSUM_EN
        $display("[TB] checksum match and mismatch");
        @(negedge pclk);
        rst_n = 1'b0;
        @(negedge pclk);
        rst_n = 1'b1;
        line_sum = 8'd0;
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(8'h01);
            push_pix(8'h80); apply_stimulus(8'h80);
            push_pix(8'h90); apply_stimulus(8'h90);
            push_pix(8'h90); push_pix(8'h90);
            apply_stimulus(8'h81);
            finish_line();
            check_output("csum_value", line_sum, 8'h30);
            apply_stimulus(line_sum + 8'(k));
            check_output("err_after_csum", 8'(err), 8'(k));
            line_sum = 8'd0;
        end
`endif

        repeat (4) @(posedge pclk);
        #1;
        check_output("scoreboard_empty", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
